// File: rtl/melody_sequencer.sv
`timescale 1ns/1ps
// melody_sequencer
// ----------------
// Steps through a small note table and drives the piano beeper stage
// directly. Each table entry holds a tone half-period and a duration in
// tempo ticks. Playback walks the table from entry 0. A short silent
// articulation gap follows every note. Playback can be one-shot or looped.
// The table can be rewritten at any time from a key/host front end.
//
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   start    : level-sampled; begins playback from entry 0 when idle
//   stop     : aborts playback (priority over start)
//   loop     : sampled at end of table; 1 restarts from entry 0
//   wr_en    : table write strobe
//   wr_addr  : table write address
//   wr_tone  : tone half-period to write (0 = rest)
//   wr_dur   : duration in ticks to write (0 = end-of-sequence marker)
//   enable   : beeper enable
//   tone     : beeper tone half-period
//   busy     : high whenever the sequencer is not idle
//   note_idx : index of the entry being played
//   done     : one-cycle pulse when a one-shot sequence completes
//
// Handshake: start/stop/loop are plain levels sampled on every rising clk
// edge. There is no ready signal. A start seen while busy is simply dropped.
// The write port is fire-and-forget and is accepted in every state.
module melody_sequencer #(
    parameter int WIDTH     = 32,
    parameter int DUR_W     = 8,
    parameter int ADDR_W    = 4,
    parameter int TICK_DIV  = 120000,
    parameter int GAP_TICKS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_tone,
    input  logic [DUR_W-1:0]  wr_dur,
    output logic              enable,
    output logic [WIDTH-1:0]  tone,
    output logic              busy,
    output logic [ADDR_W-1:0] note_idx,
    output logic              done
);

    localparam int NOTE_COUNT = 2**ADDR_W;
    localparam int PRE_W      = $clog2(TICK_DIV);
    localparam int GAP_W      = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_ADVANCE
    } state_t;

    state_t state, state_n;

    // ------------------------------------------------------------------
    // Note table: synchronous read of note_idx every cycle. A same-cycle
    // write to the address being read returns the old contents, because
    // both sides update with non-blocking assignments.
    // ------------------------------------------------------------------
    logic [WIDTH+DUR_W-1:0] mem [NOTE_COUNT];
    logic [WIDTH+DUR_W-1:0] rd_data;
    logic [WIDTH-1:0]       rd_tone;
    logic [DUR_W-1:0]       rd_dur;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_tone, wr_dur};
        end
        rd_data <= mem[note_idx];
    end

    assign rd_tone = rd_data[WIDTH+DUR_W-1:DUR_W];
    assign rd_dur  = rd_data[DUR_W-1:0];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [PRE_W-1:0]  presc, presc_n;
    logic [DUR_W-1:0]  dur_ctr, dur_n;
    logic [GAP_W-1:0]  gap_ctr, gap_n;
    logic [ADDR_W-1:0] idx_n;
    logic              en_n;
    logic [WIDTH-1:0]  tone_n;
    logic              done_n;
    logic              tick;
    logic              at_end;

    // The prescaler free-runs while busy. It is not realigned per note, so
    // the first tick of a note may come after only part of a tick period.
    assign tick = (state != S_IDLE) && (presc == PRE_MAX);

    // An end-of-sequence is either an explicit marker (dur==0) or the last
    // table entry finishing.
    assign at_end = ((state == S_LOAD) && (rd_dur == '0)) ||
                    ((state == S_ADVANCE) && (note_idx == LAST_IDX));

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            presc    <= '0;
            dur_ctr  <= '0;
            gap_ctr  <= '0;
            note_idx <= '0;
            enable   <= 1'b0;
            tone     <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            dur_ctr  <= dur_n;
            gap_ctr  <= gap_n;
            note_idx <= idx_n;
            enable   <= en_n;
            tone     <= tone_n;
            done     <= done_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        idx_n   = note_idx;
        dur_n   = dur_ctr;
        gap_n   = gap_ctr;
        en_n    = enable;
        tone_n  = tone;
        done_n  = 1'b0;

        if (stop && (state != S_IDLE)) begin
            state_n = S_IDLE;
            en_n    = 1'b0;
            tone_n  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_n = S_FETCH;
                        idx_n   = '0;
                    end
                end

                S_FETCH: begin
                    state_n = S_LOAD;
                end

                S_LOAD, S_ADVANCE: begin
                    if (at_end) begin
                        // Looping from entry 0 onto an immediate marker would
                        // spin forever, so that case finishes instead.
                        if (loop && (note_idx != '0)) begin
                            idx_n   = '0;
                            state_n = S_FETCH;
                        end else begin
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                            en_n    = 1'b0;
                            tone_n  = '0;
                        end
                    end else if (state == S_LOAD) begin
                        // Tone and enable update together here, so back-to-back
                        // notes with no gap never glitch enable low.
                        dur_n   = rd_dur;
                        tone_n  = rd_tone;
                        en_n    = (rd_tone != '0);
                        state_n = S_PLAY;
                    end else begin
                        idx_n   = note_idx + ADDR_W'(1);
                        state_n = S_FETCH;
                    end
                end

                S_PLAY: begin
                    if (tick) begin
                        if (dur_ctr == DUR_W'(1)) begin
                            if (GAP_TICKS == 0) begin
                                state_n = S_ADVANCE;
                            end else begin
                                // Tone is held through the gap; only enable drops.
                                en_n    = 1'b0;
                                gap_n   = GAP_W'(GAP_TICKS);
                                state_n = S_GAP;
                            end
                        end else begin
                            dur_n = dur_ctr - DUR_W'(1);
                        end
                    end
                end

                S_GAP: begin
                    if (tick) begin
                        if (gap_ctr == GAP_W'(1)) begin
                            state_n = S_ADVANCE;
                        end else begin
                            gap_n = gap_ctr - GAP_W'(1);
                        end
                    end
                end

                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        // Held at zero in IDLE, which also clears it on the start accept.
        if ((state == S_IDLE) || (state_n == S_IDLE) || tick) begin
            presc_n = '0;
        end else begin
            presc_n = presc + PRE_W'(1);
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
`timescale 1ns/1ps
module tb_melody_sequencer;

    // ---------------------------------------------------------------
    // Clock / reset / DUTs (dut_a has a 1-tick gap, dut_b has none)
    // ---------------------------------------------------------------
    logic        clk;
    logic        rst_n;
    logic        start_a, start_b, stop, loop;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_tone;
    logic [7:0]  wr_dur;

    logic        en_a, busy_a, done_a;
    logic [31:0] tone_a;
    logic [3:0]  idx_a;
    logic        en_b, busy_b, done_b;
    logic [31:0] tone_b;
    logic [3:0]  idx_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    melody_sequencer #(.WIDTH(32), .DUR_W(8), .ADDR_W(4), .TICK_DIV(4), .GAP_TICKS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop), .loop(loop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_tone(wr_tone), .wr_dur(wr_dur),
        .enable(en_a), .tone(tone_a), .busy(busy_a), .note_idx(idx_a), .done(done_a)
    );

    melody_sequencer #(.WIDTH(32), .DUR_W(8), .ADDR_W(4), .TICK_DIV(4), .GAP_TICKS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop), .loop(loop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_tone(wr_tone), .wr_dur(wr_dur),
        .enable(en_b), .tone(tone_b), .busy(busy_b), .note_idx(idx_b), .done(done_b)
    );

    // ---------------------------------------------------------------
    // Scoreboard state
    // ---------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;
    logic [35:0] exp_q[$];

    typedef struct packed {
        logic        start;
        logic        stop;
        logic        loop;
        logic [7:0]  reps;
        logic        en;
        logic [31:0] tone;
        logic        busy;
        logic        done;
        logic [3:0]  idx;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] t, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_tone = t;
        wr_dur  = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic add(input logic s, input logic p, input logic l, input int reps,
                       input logic en, input logic [31:0] t, input logic b,
                       input logic dn, input logic [3:0] ix);
        vec_t v;
        v.start = s; v.stop = p; v.loop = l; v.reps = 8'(reps);
        v.en = en; v.tone = t; v.busy = b; v.done = dn; v.idx = ix;
        vq.push_back(v);
    endtask

    // Each row's inputs are sampled at the next edge; its expectations
    // are checked just after that edge, repeated reps times.
    task automatic run_vecs(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            for (int r = 0; r < int'(vq[i].reps); r++) begin
                start_a = vq[i].start;
                stop    = vq[i].stop;
                loop    = vq[i].loop;
                step();
                chk($sformatf("%s_row%0d_rep%0d", tag, i, r),
                    {25'd0, en_a, tone_a, busy_a, done_a, idx_a},
                    {25'd0, vq[i].en, vq[i].tone, vq[i].busy, vq[i].done, vq[i].idx});
            end
        end
        start_a = 1'b0;
        stop    = 1'b0;
        loop    = 1'b0;
    endtask

    // ---------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------
    initial begin
        int  rises, done_cnt, hi_cnt, tone_bad, done_at, n_notes;
        logic prev_en, seen1, wrapped, done_seen, got;
        logic [35:0] e;

        // Vector table: rows 0..8 one-shot {(100,2),(0,1),(0,0)},
        // rows 9..16 entry 0 is a marker played with loop=1.
        //   st sp lp reps en tone busy done idx
        add(1, 0, 0, 1, 0, 0,   1, 0, 0);   // FETCH
        add(0, 0, 0, 1, 0, 0,   1, 0, 0);   // LOAD
        add(0, 0, 0, 6, 1, 100, 1, 0, 0);   // PLAY: 2 ticks
        add(0, 0, 0, 5, 0, 100, 1, 0, 0);   // GAP + ADVANCE, tone held
        add(0, 0, 0, 2, 0, 100, 1, 0, 1);   // FETCH/LOAD entry 1
        add(0, 0, 0, 6, 0, 0,   1, 0, 1);   // rest tick + gap + ADVANCE
        add(0, 0, 0, 2, 0, 0,   1, 0, 2);   // FETCH/LOAD marker
        add(0, 0, 0, 1, 0, 0,   0, 1, 2);   // done pulse
        add(0, 0, 0, 3, 0, 0,   0, 0, 2);   // idle afterwards
        add(1, 0, 1, 1, 0, 0,   1, 0, 0);   // FETCH
        add(1, 0, 1, 1, 0, 0,   1, 0, 0);   // LOAD (start ignored)
        add(1, 0, 1, 1, 0, 0,   0, 1, 0);   // done, no spinning
        add(1, 0, 1, 1, 0, 0,   1, 0, 0);   // held start retriggers
        add(0, 0, 1, 1, 0, 0,   1, 0, 0);   // LOAD
        add(0, 0, 1, 1, 0, 0,   0, 1, 0);   // done again
        add(1, 1, 1, 2, 0, 0,   0, 0, 0);   // stop beats start in idle
        add(0, 0, 0, 2, 0, 0,   0, 0, 0);

        rst_n = 1'b1; start_a = 0; start_b = 0; stop = 0; loop = 0;
        wr_en = 0; wr_addr = 0; wr_tone = 0; wr_dur = 0;
        #2 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("reset_a", {en_a, tone_a, busy_a, done_a, idx_a}, 0);
        chk("reset_b", {en_b, tone_b, busy_b, done_b, idx_b}, 0);

        // One-shot table
        wr(0, 100, 2); wr(1, 0, 1); wr(2, 0, 0);
        run_vecs(0, 8, "oneshot");

        // Looping the same table, then stop
        loop = 1; start_a = 1; step(); start_a = 0;
        rises = 0; done_cnt = 0; seen1 = 0; wrapped = 0; prev_en = en_a;
        for (int c = 0; c < 600 && rises < 4; c++) begin
            step();
            if (done_a) done_cnt++;
            if (idx_a == 4'd1) seen1 = 1;
            if (seen1 && idx_a == 4'd0) wrapped = 1;
            if (en_a && !prev_en) begin
                rises++;
                chk("loop_tone", tone_a, 100);
            end
            prev_en = en_a;
        end
        chk("loop_rises", rises, 4);
        chk("loop_done", done_cnt, 0);
        chk("loop_wrap", wrapped, 1);
        stop = 1; step(); stop = 0; loop = 0;
        chk("stop_out", {en_a, tone_a, busy_a, done_a}, 0);
        step();
        chk("stop_after", {busy_a, done_a}, 0);

        // Full table of 16 real notes, no marker
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 32'(i + 1), 8'd1);
            exp_q.push_back({4'(i), 32'(i + 1)});
        end
        start_a = 1; step(); start_a = 0;
        prev_en = en_a; done_seen = 0; n_notes = 0; done_cnt = 0;
        for (int c = 0; c < 1500 && !done_seen; c++) begin
            step();
            if (en_a && !prev_en) begin
                n_notes++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("seq_note", {idx_a, tone_a}, e);
                end
            end
            prev_en = en_a;
            if (done_a) begin
                done_seen = 1;
                chk("seq_done_idx", idx_a, 15);
                chk("seq_done_busy", busy_a, 0);
            end
        end
        chk("seq_done_seen", done_seen, 1);
        chk("seq_count", n_notes, 16);
        step();
        chk("seq_done_once", done_a, 0);

        // No gap: equal notes stay enabled back to back
        wr(0, 50, 1); wr(1, 50, 1); wr(2, 0, 0);
        start_b = 1; step(); start_b = 0;
        prev_en = en_b; hi_cnt = 0; rises = 0; tone_bad = 0; done_at = 0;
        for (int c = 2; c <= 20; c++) begin
            step();
            if (en_b) begin
                hi_cnt++;
                if (tone_b != 32'd50) tone_bad++;
            end
            if (en_b && !prev_en) rises++;
            prev_en = en_b;
            if (done_b) done_at = c;
        end
        chk("nogap_high_cycles", hi_cnt, 9);
        chk("nogap_rises", rises, 1);
        chk("nogap_tone", tone_bad, 0);
        chk("nogap_done_cycle", done_at, 12);

        // Marker at entry 0 with loop=1; held start; stop priority
        wr(0, 123, 0);
        run_vecs(9, 16, "marker0");

        // Rewrite the next entry mid-note, then async reset mid-note
        wr(0, 100, 3); wr(1, 200, 1); wr(2, 0, 0);
        start_a = 1; step(); start_a = 0;
        got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            step();
            if (en_a) got = 1;
        end
        chk("wr_first_play", got, 1);
        wr(1, 77, 1);
        prev_en = en_a; got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            step();
            if (en_a && !prev_en) got = 1;
            prev_en = en_a;
        end
        chk("wr_next_rise", got, 1);
        chk("wr_next_tone", tone_a, 77);
        chk("wr_next_idx", idx_a, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {en_a, tone_a, busy_a, done_a, idx_a}, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("after_reset", {en_a, busy_a, done_a}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
